// File: rtl/snake_pkg.sv
// Shared constants, coordinate type and scanner FSM states for the snake
// collision logic.
package snake_pkg;
    localparam int COORD_W   = 10;
    localparam int MAX_SEGS  = 20;
    localparam int FIRST_SEG = 2;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BORDER    = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALL = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/snake_border_gen.sv
// Registered per-pixel wall-band flag for the VGA colour mux.
// SNAKE_WRAP_MODE_EN (torus playfield) forces the flag to 0.
module snake_border_gen #(
    parameter int COORD_W  = snake_pkg::COORD_W,
    parameter int SCREEN_W = snake_pkg::SCREEN_W,
    parameter int SCREEN_H = snake_pkg::SCREEN_H,
    parameter int BORDER   = snake_pkg::BORDER
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic               o_border
);
    localparam logic [COORD_W-1:0] L_B  = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] L_XR = COORD_W'(SCREEN_W - BORDER);
    localparam logic [COORD_W-1:0] L_XE = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] L_YB = COORD_W'(SCREEN_H - BORDER);
    localparam logic [COORD_W-1:0] L_YE = COORD_W'(SCREEN_H);

    logic w_band;
    logic w_flag;

    // Off-screen (blanking) pixels beyond the far edges are not band pixels.
    assign w_band = (i_x < L_B) || ((i_x >= L_XR) && (i_x < L_XE)) ||
                    (i_y < L_B) || ((i_y >= L_YB) && (i_y < L_YE));

`ifdef SNAKE_WRAP_MODE_EN
    assign w_flag = w_band & 1'b0;
`else
    assign w_flag = w_band;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_border <= 1'b0;
        else          o_border <= w_flag;
    end
endmodule

// File: rtl/snake_collision_scanner.sv
// Per-move collision check: snapshot head/body, test wall band, then scan live
// body segments one per clock. SNAKE_WRAP_MODE_EN disables wall hits.
module snake_collision_scanner #(
    parameter int MAX_SEGS  = snake_pkg::MAX_SEGS,
    parameter int COORD_W   = snake_pkg::COORD_W,
    parameter int FIRST_SEG = snake_pkg::FIRST_SEG,
    parameter int SCREEN_W  = snake_pkg::SCREEN_W,
    parameter int SCREEN_H  = snake_pkg::SCREEN_H,
    parameter int BORDER    = snake_pkg::BORDER
) (
    input  logic                        vga_clk,
    input  logic                        rst_n,
    input  logic                        check_start,
    input  logic                        clear,
    input  logic [7:0]                  score,
    input  logic [COORD_W-1:0]          snakex,
    input  logic [COORD_W-1:0]          snakey,
    input  logic [MAX_SEGS*COORD_W-1:0] storex,
    input  logic [MAX_SEGS*COORD_W-1:0] storey,
    input  logic [COORD_W-1:0]          x,
    input  logic [COORD_W-1:0]          y,
    output logic                        border,
    output logic                        busy,
    output logic                        check_done,
    output logic                        hit_wall,
    output logic                        hit_body,
    output logic                        game_over
);
    import snake_pkg::*;

    localparam int IDX_W = $clog2(MAX_SEGS);
    localparam logic [IDX_W-1:0]   L_FIRST  = IDX_W'(FIRST_SEG);
    localparam logic [IDX_W-1:0]   L_MAXIDX = IDX_W'(MAX_SEGS - 1);
    localparam logic [COORD_W-1:0] L_B      = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] L_XR     = COORD_W'(SCREEN_W - BORDER);
    localparam logic [COORD_W-1:0] L_YB     = COORD_W'(SCREEN_H - BORDER);

    state_t                      r_state, w_state_nx;
    logic [COORD_W-1:0]          r_hx, r_hy;
    logic [MAX_SEGS*COORD_W-1:0] r_sx, r_sy;
    logic [IDX_W-1:0]            r_last, r_idx;
    logic                        r_wall, r_body;

    logic [IDX_W-1:0]   w_last;
    logic [COORD_W-1:0] w_seg_x, w_seg_y;
    logic               w_wall_hit, w_empty, w_match;

    snake_border_gen #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .BORDER   (BORDER)
    ) u_border (
        .i_clk    (vga_clk),
        .i_rst_n  (rst_n),
        .i_x      (x),
        .i_y      (y),
        .o_border (border)
    );

    assign w_last  = (score > 8'(MAX_SEGS - 1)) ? L_MAXIDX : IDX_W'(score);
    assign w_empty = (r_last < L_FIRST);
    assign w_seg_x = r_sx[int'(r_idx)*COORD_W +: COORD_W];
    assign w_seg_y = r_sy[int'(r_idx)*COORD_W +: COORD_W];
    assign w_match = (w_seg_x == r_hx) && (w_seg_y == r_hy);

`ifdef SNAKE_WRAP_MODE_EN
    assign w_wall_hit = 1'b0;
`else
    // x >= SCREEN_W-BORDER also catches heads that ran past the right edge.
    assign w_wall_hit = (r_hx < L_B) || (r_hx >= L_XR) ||
                        (r_hy < L_B) || (r_hy >= L_YB);
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (check_start) w_state_nx = WALL;
            WALL: w_state_nx = (w_wall_hit || w_empty) ? DONE : SCAN;
            SCAN: if (w_match || (r_idx == r_last)) w_state_nx = DONE;
            DONE: w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hx       <= '0;
            r_hy       <= '0;
            r_sx       <= '0;
            r_sy       <= '0;
            r_last     <= '0;
            r_idx      <= L_FIRST;
            r_wall     <= 1'b0;
            r_body     <= 1'b0;
            busy       <= 1'b0;
            check_done <= 1'b0;
            hit_wall   <= 1'b0;
            hit_body   <= 1'b0;
            game_over  <= 1'b0;
        end else if (clear) begin
            // Abort silently: no check_done for the dropped scan.
            r_state    <= IDLE;
            r_idx      <= L_FIRST;
            r_wall     <= 1'b0;
            r_body     <= 1'b0;
            busy       <= 1'b0;
            check_done <= 1'b0;
            hit_wall   <= 1'b0;
            hit_body   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            check_done <= 1'b0;
            case (r_state)
                IDLE: if (check_start) begin
                    r_hx   <= snakex;
                    r_hy   <= snakey;
                    r_sx   <= storex;
                    r_sy   <= storey;
                    r_last <= w_last;
                    r_wall <= 1'b0;
                    r_body <= 1'b0;
                    busy   <= 1'b1;
                end
                WALL: begin
                    r_wall <= w_wall_hit;
                    r_idx  <= L_FIRST;
                end
                SCAN: begin
                    if (w_match)              r_body <= 1'b1;
                    else if (r_idx != r_last) r_idx  <= r_idx + 1'b1;
                end
                DONE: begin
                    check_done <= 1'b1;
                    busy       <= 1'b0;
                    hit_wall   <= r_wall;
                    hit_body   <= r_body;
                    game_over  <= game_over | r_wall | r_body;
                    r_idx      <= L_FIRST;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_collision_scanner.sv
// Directed bench for snake_collision_scanner; expectations adapt when
// SNAKE_WRAP_MODE_EN is defined.
module tb_snake_collision_scanner;
`ifdef SNAKE_WRAP_MODE_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         vga_clk = 1'b0;
    logic         rst_n, check_start, clear;
    logic [7:0]   score;
    logic [9:0]   snakex, snakey, x, y;
    logic [199:0] storex, storey;
    logic         border, busy, check_done, hit_wall, hit_body, game_over;

    int checks = 0;
    int errors = 0;
    int lat;

    snake_collision_scanner dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .check_start(check_start), .clear(clear),
        .score(score), .snakex(snakex), .snakey(snakey), .storex(storex), .storey(storey),
        .x(x), .y(y), .border(border), .busy(busy), .check_done(check_done),
        .hit_wall(hit_wall), .hit_body(hit_body), .game_over(game_over)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int k, input int sx, input int sy);
        storex[k*10 +: 10] = 10'(sx);
        storey[k*10 +: 10] = 10'(sy);
    endtask

    task automatic fill_distinct();
        for (int k = 0; k < 20; k++) set_slot(k, 500 + k, 400 + k);
    endtask

    // Counts edges after the current one until check_done is seen; -1 if none.
    task automatic wait_done(input int bound, output int n_out);
        n_out = -1;
        for (int n = 1; n <= bound; n++) begin
            @(posedge vga_clk); #1;
            if (check_done) begin
                n_out = n;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge vga_clk); check_start = 1'b1;
        @(posedge vga_clk); #1 check_start = 1'b0;
    endtask

    task automatic run_check(output int n_out);
        pulse_start();
        wait_done(60, n_out);
    endtask

    task automatic pulse_clear();
        @(negedge vga_clk); clear = 1'b1;
        @(posedge vga_clk); #1 clear = 1'b0;
    endtask

    task automatic pix(input int px, input int py, input string tag, input bit exp);
        @(negedge vga_clk); x = 10'(px); y = 10'(py);
        @(posedge vga_clk); #1;
        chk(tag, int'(border), int'(exp & !WRAP));
    endtask

    initial begin
        rst_n = 1'b0; check_start = 1'b0; clear = 1'b0; score = 8'd0;
        snakex = 10'd300; snakey = 10'd240; x = 10'd300; y = 10'd240;
        storex = '0; storey = '0;
        fill_distinct();
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(check_done), 0);
        chk("rst_hit_wall", int'(hit_wall), 0);
        chk("rst_hit_body", int'(hit_body), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_border", int'(border), 0);
        @(negedge vga_clk); rst_n = 1'b1;

        // Wall hit: head (5,100); in wrap mode the 4 slots 2..5 are scanned.
        score = 8'd5; snakex = 10'd5; snakey = 10'd100;
        pulse_start();
        chk("wall_busy_after_start", int'(busy), 1);
        wait_done(60, lat);
        chk("wall_latency", lat, WRAP ? 6 : 2);
        chk("wall_hit_wall", int'(hit_wall), WRAP ? 0 : 1);
        chk("wall_hit_body", int'(hit_body), 0);
        chk("wall_game_over", int'(game_over), WRAP ? 0 : 1);
        @(posedge vga_clk); #1;
        chk("wall_busy_after_done", int'(busy), 0);
        chk("wall_done_pulse_one_cycle", int'(check_done), 0);
        chk("wall_hit_held", int'(hit_wall), WRAP ? 0 : 1);
        pulse_clear();
        chk("clear_game_over", int'(game_over), 0);
        chk("clear_hit_wall", int'(hit_wall), 0);

        // Body hit with early exit at slot 4.
        score = 8'd6; snakex = 10'd200; snakey = 10'd200;
        fill_distinct(); set_slot(4, 200, 200);
        run_check(lat);
        chk("body_latency", lat, 5);
        chk("body_hit_body", int'(hit_body), 1);
        chk("body_hit_wall", int'(hit_wall), 0);
        chk("body_game_over", int'(game_over), 1);
        pulse_clear();

        // Full scan, no hit: slots 2..10 compared -> 3 + 8.
        score = 8'd10; snakex = 10'd300; snakey = 10'd240; fill_distinct();
        run_check(lat);
        chk("full_latency", lat, 11);
        chk("full_hit_body", int'(hit_body), 0);
        chk("full_hit_wall", int'(hit_wall), 0);
        chk("full_game_over", int'(game_over), 0);

        // Empty scan: score=1, slot 2 equals head but is not live.
        score = 8'd1; set_slot(2, 300, 240);
        run_check(lat);
        chk("empty_latency", lat, 2);
        chk("empty_hit_body", int'(hit_body), 0);

        // Clamp: score=255 -> last_seg 19, slot 19 matches after 18 compares.
        fill_distinct(); score = 8'd255; set_slot(19, 300, 240);
        run_check(lat);
        chk("clamp_latency", lat, 20);
        chk("clamp_hit_body", int'(hit_body), 1);
        pulse_clear();
        // score=18 stops at slot 18, so slot 19 is never reached.
        score = 8'd18;
        run_check(lat);
        chk("score18_latency", lat, 19);
        chk("score18_hit_body", int'(hit_body), 0);

        // Mid-scan check_start and head change are ignored.
        fill_distinct(); score = 8'd10;
        pulse_start();
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk); check_start = 1'b1; snakex = 10'd505; snakey = 10'd405;
        @(posedge vga_clk); #1 check_start = 1'b0;
        wait_done(60, lat);
        chk("ignore_latency", lat, 7);
        chk("ignore_hit_body", int'(hit_body), 0);
        wait_done(20, lat);
        chk("ignore_no_second_done", lat, -1);
        chk("ignore_idle_busy", int'(busy), 0);

        // clear mid-scan after a wall hit.
        snakex = 10'd5; snakey = 10'd100; score = 8'd5;
        run_check(lat);
        snakex = 10'd300; snakey = 10'd240; score = 8'd10;
        pulse_start();
        repeat (3) @(posedge vga_clk);
        pulse_clear();
        chk("clrmid_busy", int'(busy), 0);
        chk("clrmid_game_over", int'(game_over), 0);
        chk("clrmid_hit_wall", int'(hit_wall), 0);
        wait_done(20, lat);
        chk("clrmid_no_done", lat, -1);

        // clear and check_start together: clear wins.
        @(negedge vga_clk); clear = 1'b1; check_start = 1'b1;
        @(posedge vga_clk); #1 clear = 1'b0; check_start = 1'b0;
        chk("clr_start_busy", int'(busy), 0);
        wait_done(10, lat);
        chk("clr_start_no_done", lat, -1);

        // Async reset mid-scan after a body hit set game_over.
        fill_distinct(); set_slot(3, 300, 240); score = 8'd6;
        run_check(lat);
        chk("pre_rst_game_over", int'(game_over), 1);
        fill_distinct(); score = 8'd10;
        pulse_start();
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk); rst_n = 1'b0; #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_game_over", int'(game_over), 0);
        chk("arst_hit_body", int'(hit_body), 0);
        @(negedge vga_clk); rst_n = 1'b1;
        wait_done(20, lat);
        chk("arst_no_done", lat, -1);

        // Border sweep with one-cycle latency.
        pix(300, 240, "bdr_center", 1'b0);
        @(negedge vga_clk); x = 10'd9; #1;
        chk("bdr_latency_pre_edge", int'(border), 0);
        @(posedge vga_clk); #1;
        chk("bdr_x9", int'(border), int'(!WRAP));
        pix(10,  240, "bdr_x10",  1'b0);
        pix(629, 240, "bdr_x629", 1'b0);
        pix(630, 240, "bdr_x630", 1'b1);
        pix(639, 240, "bdr_x639", 1'b1);
        pix(640, 240, "bdr_x640_offscreen", 1'b0);
        pix(300, 9,   "bdr_y9",   1'b1);
        pix(300, 469, "bdr_y469", 1'b0);
        pix(300, 470, "bdr_y470", 1'b1);
        pix(300, 480, "bdr_y480_offscreen", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
